signed_dot_product_accumulator: RTL and testbench
=================================================

SIGNED_DOT_PRODUCT_ACCUMULATOR -- requirements
Module: signed_dot_product_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 10, giving the signed accumulator width in bits.
REQ-002 The block SHALL have parameter MAX_LEN, default 16, giving the maximum number of products per vector.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; asynchronous and active-high.
REQ-005 The block SHALL have port prod, input, 8 bits, the signed two's-complement product z from the upstream 4-bit Baugh-Wooley multiplier.
REQ-006 The block SHALL have port in_valid, input, 1 bit, which qualifies prod.
REQ-007 The block SHALL have port in_last, input, 1 bit, which marks the final product of a vector and is sampled with prod.
REQ-008 The block SHALL have port in_ready, output, 1 bit, asserted when a product can be accepted.
REQ-009 The block SHALL have port out_sum, output, ACC_W bits, the signed accumulated dot product.
REQ-010 The block SHALL have port out_count, output, $clog2(MAX_LEN+1) bits, the number of products accumulated.
REQ-011 The block SHALL have port out_sat, output, 1 bit, set when any addition in the vector saturated.
REQ-012 The block SHALL have port out_valid, output, 1 bit, which qualifies out_sum, out_count and out_sat.
REQ-013 The block SHALL have port out_ready, input, 1 bit, the downstream acceptance signal.

Function
REQ-014 The block SHALL implement an FSM with the states IDLE, ACC and DONE.
REQ-015 An input beat SHALL be accepted iff in_valid and in_ready are both high on a rising clk edge.
REQ-016 in_ready SHALL be 1 in IDLE and ACC, and 0 in DONE; it SHALL be combinational from state only.
REQ-017 On a beat in IDLE, the block SHALL set acc to sext(prod), set count to 1 and clear sat; the next state SHALL be DONE if in_last is set, else ACC.
REQ-018 On a beat in ACC, the block SHALL set acc to sat(acc + sext(prod)) and increment count by 1.
REQ-019 From ACC, the next state SHALL be DONE if in_last is set or if the new count equals MAX_LEN; otherwise the state SHALL remain ACC.
REQ-020 sat() SHALL compute the sum at ACC_W+1 bits and clamp it to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-021 out_sat SHALL become 1 whenever sat() clamps, stay sticky until the state returns to IDLE, and later additions SHALL continue from the clamped value.
REQ-022 In IDLE and ACC, the block SHALL hold its state and registers when no beat is accepted; gaps in in_valid are legal.
REQ-023 out_valid SHALL be 1 exactly in DONE; out_sum, out_count and out_sat SHALL be registered and stable while out_valid=1.
REQ-024 In DONE with out_ready=1, the next state SHALL be IDLE and acc, count and sat SHALL clear to 0.
REQ-025 Output latency SHALL be 1 cycle: out_valid rises on the edge that accepts the terminating beat.
REQ-026 A beat presented in DONE SHALL NOT be consumed, even when out_ready=1 in the same cycle; it is accepted in IDLE on the following cycle at the earliest.
REQ-027 in_last SHALL be ignored when in_valid is 0.
REQ-028 A single-beat vector (in_last on the first beat) SHALL give out_count=1.

Reset
REQ-029 Asserting rst SHALL immediately force state IDLE, acc=0, count=0 and sat=0, giving out_valid=0, in_ready=1, out_sum=0, out_count=0 and out_sat=0.
REQ-030 Reset asserted mid-vector (in ACC or DONE) SHALL discard the partial result; the first beat after reset release SHALL start a new vector.

Verification
REQ-031 Reset check: rst pulse -> out_valid=0, in_ready=1, out_sum=0, out_count=0, out_sat=0, with no clk edge needed.
REQ-032 Basic vector: prod=5, -3, 7 on consecutive cycles, in_last on the third -> the next cycle shows out_valid=1, out_sum=9, out_count=3, out_sat=0.
REQ-033 Positive saturation and length cap: 16 beats of prod=64 (-8*-8) without in_last -> DONE after the 16th beat, out_sum=511, out_count=16, out_sat=1.
REQ-034 Negative saturation: 16 beats of prod=-56 with in_last on the 16th -> out_sum=-512, out_sat=1.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready=0 and outputs stable; then set out_ready=1 -> IDLE the next cycle, the pending beat accepted the cycle after, and out_sat cleared.
REQ-036 Reset mid-operation: assert rst after 2 accepted beats -> IDLE at once; a new vector 2, 3 with in_last -> out_sum=5, out_count=2.

Source files
------------

// File: rtl/signed_dot_product_accumulator.sv
// rtl/signed_dot_product_accumulator.sv - signed saturating dot-product accumulator
// Sums signed 8-bit products into a clamped ACC_W-bit result, one vector at a time.
module signed_dot_product_accumulator #(
  parameter int ACC_W   = 10,
  parameter int MAX_LEN = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [7:0]               prod,
  input  logic                            in_valid,
  input  logic                            in_last,
  output logic                            in_ready,
  output logic signed [ACC_W-1:0]         out_sum,
  output logic [$clog2(MAX_LEN+1)-1:0]    out_count,
  output logic                            out_sat,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int CW = $clog2(MAX_LEN+1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CW-1:0]           r_count;
  logic                    r_sat;

  logic                    w_beat;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_pos_ovf;
  logic                    w_neg_ovf;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic [CW-1:0]           w_count_inc;

  assign in_ready  = (r_state != DONE);
  assign out_valid = (r_state == DONE);
  assign out_sum   = r_acc;
  assign out_count = r_count;
  assign out_sat   = r_sat;

  assign w_beat      = in_valid & in_ready;
  assign w_count_inc = r_count + CW'(1);

  // One guard bit is enough: the top two bits disagree exactly when the sum leaves ACC_W range.
  assign w_sum     = (ACC_W+1)'(r_acc) + (ACC_W+1)'(prod);
  assign w_pos_ovf = ~w_sum[ACC_W] &  w_sum[ACC_W-1];
  assign w_neg_ovf =  w_sum[ACC_W] & ~w_sum[ACC_W-1];
  assign w_acc_nxt = w_pos_ovf ? ACC_MAX :
                     w_neg_ovf ? ACC_MIN : w_sum[ACC_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_beat) begin
            r_acc   <= ACC_W'(prod);
            r_count <= CW'(1);
            r_sat   <= 1'b0;
            r_state <= in_last ? DONE : ACC;
          end
        end
        ACC: begin
          if (w_beat) begin
            r_acc   <= w_acc_nxt;
            r_count <= w_count_inc;
            if (w_pos_ovf || w_neg_ovf) r_sat <= 1'b1;
            if (in_last || (w_count_inc == CW'(MAX_LEN))) r_state <= DONE;
          end
        end
        DONE: begin
          // The DONE beat is never consumed; the result clears as it is handed off.
          if (out_ready) begin
            r_acc   <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_dot_product_accumulator.sv
// tb/tb_signed_dot_product_accumulator.sv - self-checking bench for the dot-product accumulator
// Directed scenarios plus random vectors checked against an integer arithmetic model.
module tb_signed_dot_product_accumulator;

  localparam int ACC_W   = 10;
  localparam int MAX_LEN = 16;
  localparam int CW      = $clog2(MAX_LEN+1);
  localparam int AMAX    = (1 << (ACC_W-1)) - 1;
  localparam int AMIN    = -(1 << (ACC_W-1));

  logic                    clk;
  logic                    rst;
  logic signed [7:0]       prod;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic signed [ACC_W-1:0] out_sum;
  logic [CW-1:0]           out_count;
  logic                    out_sat;
  logic                    out_valid;
  logic                    out_ready;

  int n_pass;
  int n_checks;
  int q_prod[$];
  bit q_last[$];

  signed_dot_product_accumulator #(.ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .prod(prod), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_sum(out_sum), .out_count(out_count), .out_sat(out_sat),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives the queued vector and computes the expected result with plain integer arithmetic.
  task automatic play(input int max_gap, output int e_sum, output int e_cnt, output bit e_sat);
    int acc;
    int cnt;
    bit sat;
    int gap;
    acc = 0; cnt = 0; sat = 0;
    for (int i = 0; i < q_prod.size(); i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'($urandom_range(1, 0)); prod = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1; prod = 8'(q_prod[i]); in_last = q_last[i];
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      if (i == 0) begin
        acc = q_prod[i]; cnt = 1; sat = 0;
      end else begin
        acc = acc + q_prod[i]; cnt++;
        if (acc > AMAX) begin acc = AMAX; sat = 1; end
        else if (acc < AMIN) begin acc = AMIN; sat = 1; end
      end
      if (q_last[i] || (i > 0 && cnt == MAX_LEN)) break;
    end
    e_sum = acc; e_cnt = cnt; e_sat = sat;
  endtask

  task automatic drain();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    q_prod = '{10, 20}; q_last = '{0, 0};
    begin
      int s; int c; bit t;
      play(0, s, c, t);
    end
    @(negedge clk); #2; rst = 1'b1; #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || out_count !== '0 || out_sat !== 1'b0)
      $display("FAIL reset: valid=%b ready=%b sum=%0d count=%0d sat=%b required 0 1 0 0 0",
               out_valid, in_ready, out_sum, out_count, out_sat);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    int s; int c; bit t;
    q_prod = '{5, -3, 7}; q_last = '{0, 0, 1};
    play(0, s, c, t);
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 10'sd9 || out_count !== CW'(3) || out_sat !== 1'b0)
      $display("FAIL basic: valid=%b sum=%0d count=%0d sat=%b required 1 9 3 0",
               out_valid, out_sum, out_count, out_sat);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL basic_in_ready_done: got %b required 0", in_ready);
    else n_pass++;
    drain();
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0 || in_ready !== 1'b1)
      $display("FAIL basic_clear: valid=%b sum=%0d count=%0d ready=%b required 0 0 0 1",
               out_valid, out_sum, out_count, in_ready);
    else n_pass++;
  endtask

  task automatic test_pos_sat();
    int s; int c; bit t;
    q_prod.delete(); q_last.delete();
    for (int i = 0; i < MAX_LEN; i++) begin q_prod.push_back(64); q_last.push_back(0); end
    play(0, s, c, t);
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 10'sd511 || out_count !== CW'(16) || out_sat !== 1'b1)
      $display("FAIL pos_sat: valid=%b sum=%0d count=%0d sat=%b required 1 511 16 1",
               out_valid, out_sum, out_count, out_sat);
    else n_pass++;
  endtask

  // Entered with a saturated result pending from test_pos_sat.
  task automatic test_backpressure();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; prod = 8'sd3; in_last = 1'b1; out_ready = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 10'sd511 ||
          out_count !== CW'(16) || out_sat !== 1'b1)
        $display("FAIL bp_hold%0d: ready=%b valid=%b sum=%0d count=%0d sat=%b required 0 1 511 16 1",
                 k, in_ready, out_valid, out_sum, out_count, out_sat);
      else n_pass++;
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_sat !== 1'b0 || out_sum !== '0 || in_ready !== 1'b1)
      $display("FAIL bp_release: valid=%b sat=%b sum=%0d ready=%b required 0 0 0 1",
               out_valid, out_sat, out_sum, in_ready);
    else n_pass++;
    @(posedge clk); #1; in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 10'sd3 || out_count !== CW'(1) || out_sat !== 1'b0)
      $display("FAIL bp_pending_beat: valid=%b sum=%0d count=%0d sat=%b required 1 3 1 0",
               out_valid, out_sum, out_count, out_sat);
    else n_pass++;
    drain();
  endtask

  task automatic test_neg_sat();
    int s; int c; bit t;
    q_prod.delete(); q_last.delete();
    for (int i = 0; i < MAX_LEN; i++) begin q_prod.push_back(-56); q_last.push_back(i == MAX_LEN-1); end
    play(1, s, c, t);
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== -10'sd512 || out_count !== CW'(16) || out_sat !== 1'b1)
      $display("FAIL neg_sat: valid=%b sum=%0d count=%0d sat=%b required 1 -512 16 1",
               out_valid, out_sum, out_count, out_sat);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    int s; int c; bit t;
    q_prod = '{40, -7}; q_last = '{0, 0};
    play(0, s, c, t);
    @(negedge clk); #2; rst = 1'b1; #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_count !== '0 || out_sum !== '0 || in_ready !== 1'b1)
      $display("FAIL reset_mid: valid=%b count=%0d sum=%0d ready=%b required 0 0 0 1",
               out_valid, out_count, out_sum, in_ready);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    q_prod = '{2, 3}; q_last = '{0, 1};
    play(0, s, c, t);
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 10'sd5 || out_count !== CW'(2) || out_sat !== 1'b0)
      $display("FAIL reset_mid_new: valid=%b sum=%0d count=%0d sat=%b required 1 5 2 0",
               out_valid, out_sum, out_count, out_sat);
    else n_pass++;
    drain();
  endtask

  task automatic test_random();
    int s; int c; bit t; int len; int v;
    for (int n = 0; n < 40; n++) begin
      q_prod.delete(); q_last.delete();
      len = int'($urandom_range(MAX_LEN, 1));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(3, 0) == 0) v = ($urandom_range(1, 0) != 0) ? 127 : -128;
        else v = int'($urandom_range(255, 0)) - 128;
        q_prod.push_back(v);
        if (i != len-1) q_last.push_back(0);
        else if (len == MAX_LEN) q_last.push_back(1'($urandom_range(1, 0)));
        else q_last.push_back(1);
      end
      play(2, s, c, t);
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== ACC_W'(s) || out_count !== CW'(c) || out_sat !== t)
        $display("FAIL random%0d: valid=%b sum=%0d count=%0d sat=%b required 1 %0d %0d %0d",
                 n, out_valid, out_sum, out_count, out_sat, s, c, t);
      else n_pass++;
      drain();
      n_checks++;
      if (out_valid !== 1'b0 || out_count !== '0)
        $display("FAIL random_clear%0d: valid=%b count=%0d required 0 0", n, out_valid, out_count);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0; n_checks = 0;
    rst = 1'b1; prod = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || out_count !== '0 || out_sat !== 1'b0)
      $display("FAIL power_on_reset: valid=%b ready=%b sum=%0d count=%0d sat=%b required 0 1 0 0 0",
               out_valid, in_ready, out_sum, out_count, out_sat);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    test_reset();
    test_basic();
    test_pos_sat();
    test_backpressure();
    test_neg_sat();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
